// File: rtl/fp_vector_recorder.sv
// fp_vector_recorder: captures fp_unit request/response pairs as 156-bit
// vector records (fpu.dat layout) and streams them out on valid/ready.
// A pending FIFO holds issued requests until fp_unit responds in order;
// each response is packed with the oldest pending request into a
// first-word-fall-through output FIFO.
module fp_vector_recorder #(
    parameter int unsigned PEND_DEPTH = 4,
    parameter int unsigned OUT_DEPTH  = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         req_valid,
    input  logic [31:0]                  req_data1,
    input  logic [31:0]                  req_data2,
    input  logic [31:0]                  req_data3,
    input  logic [2:0]                   req_rm,
    input  logic [1:0]                   req_op,
    input  logic [9:0]                   req_opcode,
    input  logic                         rsp_ready,
    input  logic [31:0]                  rsp_result,
    input  logic [4:0]                   rsp_flags,
    output logic                         rec_valid,
    input  logic                         rec_ready,
    output logic [155:0]                 rec_data,
    output logic [$clog2(OUT_DEPTH):0]   rec_count,
    output logic                         err_drop,
    output logic                         err_orphan
);

    localparam int unsigned PW      = $clog2(PEND_DEPTH);
    localparam int unsigned OW      = $clog2(OUT_DEPTH);
    localparam int unsigned TUPLE_W = 111;
    localparam int unsigned REC_W   = 156;

    // ------------------------------------------------------------------
    // Pending request queue
    // ------------------------------------------------------------------
    logic [TUPLE_W-1:0] pend_mem [PEND_DEPTH];
    logic [PW:0]        pend_wr;
    logic [PW:0]        pend_rd;
    logic               pend_empty;
    logic               pend_full;
    logic               pend_push;
    logic               pend_pop;
    logic               req_drop;
    logic               rsp_orphan;
    logic [TUPLE_W-1:0] req_tuple;
    logic [TUPLE_W-1:0] pend_head;

    // Full/empty from pointer MSB compare; push-when-full allowed only with a same-cycle pop
    always_comb begin
        pend_empty = (pend_wr == pend_rd);
        pend_full  = (pend_wr[PW] != pend_rd[PW]) &&
                     (pend_wr[PW-1:0] == pend_rd[PW-1:0]);
        pend_pop   = rsp_ready && !pend_empty;
        rsp_orphan = rsp_ready && pend_empty;
        pend_push  = req_valid && (!pend_full || pend_pop);
        req_drop   = req_valid && pend_full && !pend_pop;
        req_tuple  = {req_data1, req_data2, req_data3, req_rm, req_op, req_opcode};
        pend_head  = pend_mem[pend_rd[PW-1:0]];
    end

    // Pending storage: head is read combinationally before the edge, so a
    // full-queue push+pop that lands on the head slot is safe.
    always_ff @(posedge clock) begin
        if (pend_push) begin
            pend_mem[pend_wr[PW-1:0]] <= req_tuple;
        end
    end

    // Pending queue pointers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_wr <= '0;
            pend_rd <= '0;
        end else begin
            if (pend_push) begin
                pend_wr <= pend_wr + 1'b1;
            end
            if (pend_pop) begin
                pend_rd <= pend_rd + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Record packing
    // ------------------------------------------------------------------
    logic [REC_W-1:0] packed_rec;
    logic [31:0]      head_data1;
    logic [31:0]      head_data2;
    logic [31:0]      head_data3;
    logic [2:0]       head_rm;
    logic [1:0]       head_op;
    logic [9:0]       head_opcode;

    // Unpack the head tuple and build the vector record with reserved bits zero
    always_comb begin
        {head_data1, head_data2, head_data3, head_rm, head_op, head_opcode} = pend_head;
        packed_rec = {head_data1, head_data2, head_data3, rsp_result,
                      3'b000, rsp_flags, 1'b0, head_rm, 2'b00, head_op,
                      2'b00, head_opcode};
    end

    // ------------------------------------------------------------------
    // Output record queue (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [REC_W-1:0] out_mem [OUT_DEPTH];
    logic [OW:0]      out_wr;
    logic [OW:0]      out_rd;
    logic             out_empty;
    logic             out_full;
    logic             out_write;
    logic             out_push;
    logic             out_pop;
    logic             rec_drop;

    // Output queue control; a write when full is accepted only alongside a pop
    always_comb begin
        out_empty = (out_wr == out_rd);
        out_full  = (out_wr[OW] != out_rd[OW]) &&
                    (out_wr[OW-1:0] == out_rd[OW-1:0]);
        out_write = pend_pop;
        out_pop   = !out_empty && rec_ready;
        out_push  = out_write && (!out_full || out_pop);
        rec_drop  = out_write && out_full && !out_pop;
    end

    // Output storage
    always_ff @(posedge clock) begin
        if (out_push) begin
            out_mem[out_wr[OW-1:0]] <= packed_rec;
        end
    end

    // Output queue pointers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_wr <= '0;
            out_rd <= '0;
        end else begin
            if (out_push) begin
                out_wr <= out_wr + 1'b1;
            end
            if (out_pop) begin
                out_rd <= out_rd + 1'b1;
            end
        end
    end

    // Stream outputs: head record when non-empty, all-zero otherwise
    always_comb begin
        rec_valid = !out_empty;
        rec_count = out_wr - out_rd;
        rec_data  = '0;
        if (!out_empty) begin
            rec_data = out_mem[out_rd[OW-1:0]];
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags, cleared only by reset
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_drop   <= 1'b0;
            err_orphan <= 1'b0;
        end else begin
            if (req_drop || rec_drop) begin
                err_drop <= 1'b1;
            end
            if (rsp_orphan) begin
                err_orphan <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp_vector_recorder.sv
// Directed bench for fp_vector_recorder: a table of per-cycle vectors for
// the basic and back-to-back cases, plus hand sequences for overflow,
// orphan responses, output backpressure and asynchronous reset.
module tb_fp_vector_recorder;

    logic         clock;
    logic         reset;
    logic         req_valid;
    logic [31:0]  req_data1;
    logic [31:0]  req_data2;
    logic [31:0]  req_data3;
    logic [2:0]   req_rm;
    logic [1:0]   req_op;
    logic [9:0]   req_opcode;
    logic         rsp_ready;
    logic [31:0]  rsp_result;
    logic [4:0]   rsp_flags;
    logic         rec_valid;
    logic         rec_ready;
    logic [155:0] rec_data;
    logic [3:0]   rec_count;
    logic         err_drop;
    logic         err_orphan;

    int checks = 0;
    int errors = 0;

    fp_vector_recorder #(.PEND_DEPTH(4), .OUT_DEPTH(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data1  (req_data1),
        .req_data2  (req_data2),
        .req_data3  (req_data3),
        .req_rm     (req_rm),
        .req_op     (req_op),
        .req_opcode (req_opcode),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_data   (rec_data),
        .rec_count  (rec_count),
        .err_drop   (err_drop),
        .err_orphan (err_orphan)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic         rv;
        logic [31:0]  d1;
        logic [31:0]  d2;
        logic [31:0]  d3;
        logic [2:0]   rm;
        logic [1:0]   op;
        logic [9:0]   oc;
        logic         sv;
        logic [31:0]  res;
        logic [4:0]   fl;
        logic         rr;
        logic         ev;
        logic [3:0]   ecnt;
        logic [155:0] edata;
        logic         edrop;
        logic         eorph;
    } vec_t;

    vec_t tbl [16];

    function automatic logic [155:0] mkrec(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] r,
                                           input logic [4:0] f, input logic [2:0] rm,
                                           input logic [1:0] op, input logic [9:0] oc);
        logic [155:0] x;
        x = '0;
        x[155:124] = a;
        x[123:92]  = b;
        x[91:60]   = c;
        x[59:28]   = r;
        x[24:20]   = f;
        x[18:16]   = rm;
        x[13:12]   = op;
        x[9:0]     = oc;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [155:0] act, input logic [155:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] d3, input logic [2:0] rm, input logic [1:0] op,
                         input logic [9:0] oc, input logic sv, input logic [31:0] res,
                         input logic [4:0] fl, input logic rr);
        req_valid  = rv;
        req_data1  = d1;
        req_data2  = d2;
        req_data3  = d3;
        req_rm     = rm;
        req_op     = op;
        req_opcode = oc;
        rsp_ready  = sv;
        rsp_result = res;
        rsp_flags  = fl;
        rec_ready  = rr;
    endtask

    task automatic idle(input logic rr);
        drive(1'b0, '0, '0, '0, '0, '0, '0, 1'b0, '0, '0, rr);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle(1'b0);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        step();
    endtask

    logic [155:0] rec1, rec_m, rec_d, rec_s, rec_c;

    initial begin
        reset = 1'b0;
        idle(1'b0);
        #1;
        chk("reset_valid", 156'(rec_valid), 156'(0));
        chk("reset_count", 156'(rec_count), 156'(0));
        chk("reset_data", rec_data, '0);
        chk("reset_drop", 156'(err_drop), 156'(0));
        chk("reset_orphan", 156'(err_orphan), 156'(0));
        #11;
        reset = 1'b1;
        step();

        rec1  = mkrec(32'h3F800000, 32'h40000000, 32'h0, 32'h40400000, 5'h00, 3'd0, 2'd0, 10'h002);
        rec_m = mkrec(32'h40400000, 32'h40800000, 32'h0, 32'h41400000, 5'h00, 3'd1, 2'd0, 10'h008);
        rec_d = mkrec(32'h41000000, 32'h40000000, 32'h0, 32'h40800000, 5'h01, 3'd2, 2'd0, 10'h010);
        rec_s = mkrec(32'h41800000, 32'h0, 32'h0, 32'h40800000, 5'h10, 3'd3, 2'd0, 10'h020);
        rec_c = mkrec(32'h3F800000, 32'h3F800000, 32'h0, 32'h00000001, 5'h00, 3'd2, 2'd3, 10'h040);

        // rv d1 d2 d3 rm op oc | sv res fl | rr | ev ecnt edata edrop eorph
        tbl[0]  = '{1'b1, 32'h3F800000, 32'h40000000, 32'h0, 3'd0, 2'd0, 10'h002, 1'b0, 32'h0, 5'h00, 1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0, 10'h000, 1'b0, 32'h0, 5'h00, 1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0, 10'h000, 1'b1, 32'h40400000, 5'h00, 1'b0, 1'b1, 4'd1, rec1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0, 10'h000, 1'b0, 32'h0, 5'h00, 1'b1, 1'b0, 4'd0, '0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 32'h40400000, 32'h40800000, 32'h0, 3'd1, 2'd0, 10'h008, 1'b0, 32'h0, 5'h00, 1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 32'h41000000, 32'h40000000, 32'h0, 3'd2, 2'd0, 10'h010, 1'b0, 32'h0, 5'h00, 1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 32'h41800000, 32'h0, 32'h0, 3'd3, 2'd0, 10'h020, 1'b0, 32'h0, 5'h00, 1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 32'h3F800000, 32'h3F800000, 32'h0, 3'd2, 2'd3, 10'h040, 1'b0, 32'h0, 5'h00, 1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0, 10'h000, 1'b1, 32'h41400000, 5'h00, 1'b0, 1'b1, 4'd1, rec_m, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0, 10'h000, 1'b1, 32'h40800000, 5'h01, 1'b0, 1'b1, 4'd2, rec_m, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0, 10'h000, 1'b1, 32'h40800000, 5'h10, 1'b0, 1'b1, 4'd3, rec_m, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0, 10'h000, 1'b1, 32'h00000001, 5'h00, 1'b0, 1'b1, 4'd4, rec_m, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0, 10'h000, 1'b0, 32'h0, 5'h00, 1'b1, 1'b1, 4'd3, rec_d, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0, 10'h000, 1'b0, 32'h0, 5'h00, 1'b1, 1'b1, 4'd2, rec_s, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0, 10'h000, 1'b0, 32'h0, 5'h00, 1'b1, 1'b1, 4'd1, rec_c, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0, 10'h000, 1'b0, 32'h0, 5'h00, 1'b1, 1'b0, 4'd0, '0, 1'b0, 1'b0};

        // Tests 1 and 2: single fadd, then four back-to-back ops
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rv, tbl[i].d1, tbl[i].d2, tbl[i].d3, tbl[i].rm, tbl[i].op,
                  tbl[i].oc, tbl[i].sv, tbl[i].res, tbl[i].fl, tbl[i].rr);
            step();
            chk($sformatf("v%0d_valid", i), 156'(rec_valid), 156'(tbl[i].ev));
            chk($sformatf("v%0d_count", i), 156'(rec_count), 156'(tbl[i].ecnt));
            chk($sformatf("v%0d_data", i), rec_data, tbl[i].edata);
            chk($sformatf("v%0d_drop", i), 156'(err_drop), 156'(tbl[i].edrop));
            chk($sformatf("v%0d_orphan", i), 156'(err_orphan), 156'(tbl[i].eorph));
        end

        // Test 3: pending overflow
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'(i + 1), '0, '0, '0, '0, 10'h002, 1'b0, '0, '0, 1'b0);
            step();
            chk($sformatf("t3_drop_%0d", i), 156'(err_drop), 156'(i == 4 ? 1 : 0));
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, '0, '0, '0, '0, '0, 1'b1, 32'(32'h100 + i), '0, 1'b0);
            step();
        end
        idle(1'b0);
        chk("t3_count", 156'(rec_count), 156'(4));
        chk("t3_orphan", 156'(err_orphan), 156'(0));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t3_rec_%0d", k), rec_data,
                mkrec(32'(k + 1), '0, '0, 32'(32'h100 + k), '0, '0, '0, 10'h002));
            idle(1'b1);
            step();
        end
        chk("t3_empty", 156'(rec_valid), 156'(0));

        // Test 4: orphan response, then simultaneous push/pop on pending
        do_reset();
        drive(1'b0, '0, '0, '0, '0, '0, '0, 1'b1, 32'h12345678, '0, 1'b0);
        step();
        chk("t4_orphan", 156'(err_orphan), 156'(1));
        chk("t4_count0", 156'(rec_count), 156'(0));
        chk("t4_valid0", 156'(rec_valid), 156'(0));
        drive(1'b1, 32'hAAAA0001, '0, '0, 3'd1, '0, 10'h008, 1'b0, '0, '0, 1'b0);
        step();
        drive(1'b1, 32'hBBBB0002, '0, '0, 3'd2, '0, 10'h010, 1'b1, 32'h11111111, 5'h02, 1'b0);
        step();
        chk("t4_count1", 156'(rec_count), 156'(1));
        chk("t4_recA", rec_data, mkrec(32'hAAAA0001, '0, '0, 32'h11111111, 5'h02, 3'd1, '0, 10'h008));
        drive(1'b0, '0, '0, '0, '0, '0, '0, 1'b1, 32'h22222222, 5'h04, 1'b0);
        step();
        chk("t4_count2", 156'(rec_count), 156'(2));
        drive(1'b0, '0, '0, '0, '0, '0, '0, 1'b1, 32'h33333333, 5'h00, 1'b0);
        step();
        chk("t4_count_extra", 156'(rec_count), 156'(2));
        chk("t4_drop", 156'(err_drop), 156'(0));
        idle(1'b1);
        step();
        chk("t4_recB", rec_data, mkrec(32'hBBBB0002, '0, '0, 32'h22222222, 5'h04, 3'd2, '0, 10'h010));

        // Test 5: output overflow under backpressure, then write accepted with pop
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 32'(32'hC0000000 + i), '0, 32'(i), '0, '0, 10'h001, 1'b0, '0, '0, 1'b0);
            step();
            drive(1'b0, '0, '0, '0, '0, '0, '0, 1'b1, 32'(i), '0, 1'b0);
            step();
            if (i == 7) chk("t5_drop_before", 156'(err_drop), 156'(0));
        end
        idle(1'b0);
        chk("t5_count_full", 156'(rec_count), 156'(8));
        chk("t5_drop", 156'(err_drop), 156'(1));
        chk("t5_head", rec_data, mkrec(32'hC0000000, '0, '0, '0, '0, '0, '0, 10'h001));
        drive(1'b1, 32'hC0000009, '0, 32'd9, '0, '0, 10'h001, 1'b0, '0, '0, 1'b0);
        step();
        drive(1'b0, '0, '0, '0, '0, '0, '0, 1'b1, 32'd9, '0, 1'b1);
        step();
        idle(1'b0);
        chk("t5_count_after", 156'(rec_count), 156'(8));
        for (int k = 1; k <= 8; k++) begin
            int e;
            e = (k < 8) ? k : 9;
            chk($sformatf("t5_rec_%0d", k), rec_data,
                mkrec(32'(32'hC0000000 + e), '0, 32'(e), 32'(e), '0, '0, '0, 10'h001));
            idle(1'b1);
            step();
        end
        chk("t5_drained", 156'(rec_count), 156'(0));

        // Test 6: asynchronous reset with records buffered
        do_reset();
        drive(1'b0, '0, '0, '0, '0, '0, '0, 1'b1, '0, '0, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(i + 7), '0, '0, '0, '0, 10'h200, 1'b0, '0, '0, 1'b0);
            step();
            drive(1'b0, '0, '0, '0, '0, '0, '0, 1'b1, 32'(i), '0, 1'b0);
            step();
        end
        idle(1'b0);
        chk("t6_count3", 156'(rec_count), 156'(3));
        chk("t6_orphan_set", 156'(err_orphan), 156'(1));
        #2;
        reset = 1'b0;
        #1;
        chk("t6_valid", 156'(rec_valid), 156'(0));
        chk("t6_count", 156'(rec_count), 156'(0));
        chk("t6_data", rec_data, '0);
        chk("t6_drop", 156'(err_drop), 156'(0));
        chk("t6_orphan", 156'(err_orphan), 156'(0));
        #3;
        reset = 1'b1;
        step();
        chk("t6_after_release", 156'(rec_valid), 156'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
